// File: rtl/ysyx_22040365_wb_arb_pkg.sv
// Shared constants for the write-back arbiter: XLEN, register count and RV64 load funct3 codes.
package ysyx_22040365_wb_arb_pkg;

    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/ysyx_22040365_wb_arb_load_fmt.sv
// Combinational load formatter: picks the byte/half/word lane from an aligned
// 64-bit memory word and sign- or zero-extends it according to funct3.
module ysyx_22040365_load_fmt
    import ysyx_22040365_wb_arb_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [2:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;

    // Offset bits below the access size are ignored, so misaligned
    // addresses fall back to the containing aligned lane.
    always_comb begin
        byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v = rdata_i[{addr_lo_i[2:1], 4'b0000} +: 16];
        word_v = rdata_i[{addr_lo_i[2], 5'b00000} +: 32];
        case (funct3_i)
            F3_LB:   data_o = {{56{byte_v[7]}}, byte_v};
            F3_LH:   data_o = {{48{half_v[15]}}, half_v};
            F3_LW:   data_o = {{32{word_v[31]}}, word_v};
            F3_LD:   data_o = rdata_i;
            F3_LBU:  data_o = {56'd0, byte_v};
            F3_LHU:  data_o = {48'd0, half_v};
            F3_LWU:  data_o = {32'd0, word_v};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040365_wb_arb.sv
// Write-back arbiter (LSU priority over ALU) with a registered regfile write port
// and a pending-load busy scoreboard. Define YSYX_22040365_WB_CNT_EN to add retire_cnt.
module ysyx_22040365_wb_arb
    import ysyx_22040365_wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    input  logic [2:0]            lsu_funct3,
    input  logic [2:0]            lsu_addr_lo,
    input  logic                  ld_issue,
    input  logic [ADDR_WIDTH-1:0] ld_issue_rd,
    input  logic [ADDR_WIDTH-1:0] q_rs1,
    input  logic [ADDR_WIDTH-1:0] q_rs2,
    output logic                  hazard,
`ifdef YSYX_22040365_WB_CNT_EN
    output logic [63:0]           retire_cnt,
`endif
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic [DATA_WIDTH-1:0] fmt_data;
    logic                  lsu_acc;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    ysyx_22040365_load_fmt u_load_fmt (
        .rdata_i   (lsu_rdata),
        .funct3_i  (lsu_funct3),
        .addr_lo_i (lsu_addr_lo),
        .data_o    (fmt_data)
    );

    assign lsu_ready = 1'b1;
    assign alu_ready = ~lsu_valid;
    assign lsu_acc   = lsu_valid;
    assign accept    = lsu_valid | alu_valid;

    always_comb begin
        sel_rd   = lsu_valid ? lsu_rd : alu_rd;
        sel_data = lsu_valid ? fmt_data : alu_data;
        wen_d    = accept && (sel_rd != '0);
        waddr_d  = wen_d ? sel_rd : waddr_q;
        wdata_d  = wen_d ? sel_data : wdata_q;
    end

    // Per-register busy bit: an issue in the same cycle as a writeback wins.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                assign busy_d[gi] = (ld_issue && (ld_issue_rd == ADDR_WIDTH'(gi)))
                                  | (busy_q[gi] & ~(lsu_acc && (lsu_rd == ADDR_WIDTH'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign hazard   = ((q_rs1 != '0) & busy_q[q_rs1]) | ((q_rs2 != '0) & busy_q[q_rs2]);
    assign rf_wen   = wen_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

`ifdef YSYX_22040365_WB_CNT_EN
    logic [63:0] cnt_q, cnt_d;

    assign cnt_d = accept ? cnt_q + 64'd1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22040365_wb_arb.sv
// Bench for the write-back arbiter: vector table through a one-deep expected-write
// queue, plus hand-written scoreboard and asynchronous reset sequences.
module tb_ysyx_22040365_wb_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [63:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [63:0] lsu_rdata = '0;
    logic [2:0]  lsu_funct3 = '0;
    logic [2:0]  lsu_addr_lo = '0;
    logic        ld_issue = 1'b0;
    logic [4:0]  ld_issue_rd = '0;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic        hazard;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
`ifdef YSYX_22040365_WB_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_22040365_wb_arb dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_rdata   (lsu_rdata),
        .lsu_funct3  (lsu_funct3),
        .lsu_addr_lo (lsu_addr_lo),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .q_rs1       (q_rs1),
        .q_rs2       (q_rs2),
        .hazard      (hazard),
`ifdef YSYX_22040365_WB_CNT_EN
        .retire_cnt  (retire_cnt),
`endif
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    typedef struct {
        string       name;
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [63:0] alu_d;
        logic        lsu_v;
        logic [4:0]  lsu_rd;
        logic [63:0] rdata;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic        exp_alu_ready;
        logic        exp_wen;
        logic [4:0]  exp_addr;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        string       name;
        logic        wen;
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    vec_t vecs[$];
    wr_t  exp_q[$];

    localparam logic [63:0] RD = 64'h80FF_7F01_8000_00FF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic vec_t mk(string n, logic av, logic [4:0] ard, logic [63:0] ad,
                                logic lv, logic [4:0] lrd, logic [63:0] rdat,
                                logic [2:0] f3, logic [2:0] off,
                                logic ear, logic ew, logic [4:0] ea, logic [63:0] ed);
        vec_t v;
        v.name = n; v.alu_v = av; v.alu_rd = ard; v.alu_d = ad;
        v.lsu_v = lv; v.lsu_rd = lrd; v.rdata = rdat; v.f3 = f3; v.off = off;
        v.exp_alu_ready = ear; v.exp_wen = ew; v.exp_addr = ea; v.exp_data = ed;
        return v;
    endfunction

    task automatic idle_inputs();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        ld_issue  = 1'b0;
    endtask

    // Compare the registered write port against the oldest expected write.
    task automatic check_write();
        wr_t w;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_empty: got none required one entry");
            return;
        end
        w = exp_q.pop_front();
        chk({w.name, "_wen"}, 64'(rf_wen), 64'(w.wen));
        if (w.wen) begin
            chk({w.name, "_waddr"}, 64'(rf_waddr), 64'(w.addr));
            chk({w.name, "_wdata"}, rf_wdata, w.data);
        end
    endtask

    initial begin
        // Vector table: one cycle each, output visible after the edge.
        vecs.push_back(mk("alu_rd5",     1, 5, 64'h1234, 0, 0, 0, 0, 0, 1, 1, 5, 64'h1234));
        vecs.push_back(mk("idle",        0, 0, 0,        0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("collide_lsu", 1, 3, 64'hAAAA, 1, 4, 64'hDEAD, 3'b011, 0, 0, 1, 4, 64'hDEAD));
        vecs.push_back(mk("collide_alu", 1, 3, 64'hAAAA, 0, 0, 0, 0, 0, 1, 1, 3, 64'hAAAA));
        vecs.push_back(mk("lb_off0",     0, 0, 0, 1, 10, RD, 3'b000, 0, 0, 1, 10, 64'hFFFF_FFFF_FFFF_FFFF));
        vecs.push_back(mk("lbu_off0",    0, 0, 0, 1, 11, RD, 3'b100, 0, 0, 1, 11, 64'h0000_0000_0000_00FF));
        vecs.push_back(mk("lh_off2",     0, 0, 0, 1, 12, RD, 3'b001, 2, 0, 1, 12, 64'hFFFF_FFFF_FFFF_8000));
        vecs.push_back(mk("lh_off0",     0, 0, 0, 1, 12, RD, 3'b001, 0, 0, 1, 12, 64'h0000_0000_0000_00FF));
        vecs.push_back(mk("lw_off4",     0, 0, 0, 1, 13, RD, 3'b010, 4, 0, 1, 13, 64'hFFFF_FFFF_80FF_7F01));
        vecs.push_back(mk("lwu_off4",    0, 0, 0, 1, 14, RD, 3'b110, 4, 0, 1, 14, 64'h0000_0000_80FF_7F01));
        vecs.push_back(mk("ld_off0",     0, 0, 0, 1, 15, RD, 3'b011, 0, 0, 1, 15, RD));
        vecs.push_back(mk("lhu_off7",    0, 0, 0, 1, 16, RD, 3'b101, 7, 0, 1, 16, 64'h0000_0000_0000_80FF));
        vecs.push_back(mk("lb_off5",     0, 0, 0, 1, 17, RD, 3'b000, 5, 0, 1, 17, 64'h0000_0000_0000_007F));
        vecs.push_back(mk("lw_misal6",   0, 0, 0, 1, 18, RD, 3'b010, 6, 0, 1, 18, 64'hFFFF_FFFF_80FF_7F01));
        vecs.push_back(mk("f3_111",      0, 0, 0, 1, 19, RD, 3'b111, 0, 0, 1, 19, 64'h0));
        vecs.push_back(mk("alu_x0",      1, 0, 64'h5555, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("lsu_x0",      0, 0, 0, 1, 0, RD, 3'b011, 0, 0, 0, 0, 0));

        // Reset state, and ready behaviour while held in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", 64'(rf_wen), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_hazard", 64'(hazard), 64'd0);
        lsu_valid = 1'b1;
        #1;
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        lsu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            wr_t w;
            @(negedge clk);
            alu_valid   = vecs[i].alu_v;
            alu_rd      = vecs[i].alu_rd;
            alu_data    = vecs[i].alu_d;
            lsu_valid   = vecs[i].lsu_v;
            lsu_rd      = vecs[i].lsu_rd;
            lsu_rdata   = vecs[i].rdata;
            lsu_funct3  = vecs[i].f3;
            lsu_addr_lo = vecs[i].off;
            #1;
            chk({vecs[i].name, "_alu_ready"}, 64'(alu_ready), 64'(vecs[i].exp_alu_ready));
            chk({vecs[i].name, "_lsu_ready"}, 64'(lsu_ready), 64'd1);
            w.name = vecs[i].name; w.wen = vecs[i].exp_wen;
            w.addr = vecs[i].exp_addr; w.data = vecs[i].exp_data;
            exp_q.push_back(w);
            @(posedge clk);
            #1;
            check_write();
        end

        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("idle_after_wen", 64'(rf_wen), 64'd0);

        // ld_issue to x0 never marks busy.
        @(negedge clk);
        ld_issue = 1'b1; ld_issue_rd = 5'd0; q_rs1 = 5'd0; q_rs2 = 5'd0;
        @(posedge clk);
        #1;
        chk("x0_issue_hazard", 64'(hazard), 64'd0);

        // Issue rd=7: not visible before the edge, visible after.
        @(negedge clk);
        ld_issue = 1'b1; ld_issue_rd = 5'd7; q_rs2 = 5'd7;
        #1;
        chk("sb_no_bypass", 64'(hazard), 64'd0);
        @(posedge clk);
        #1;
        chk("sb_set7_rs2", 64'(hazard), 64'd1);

        // ALU write to rd=7 leaves the busy bit alone.
        @(negedge clk);
        ld_issue = 1'b0; alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
        @(posedge clk);
        #1;
        chk("sb_alu_keeps", 64'(hazard), 64'd1);

        // LSU writeback to rd=7 clears it.
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_funct3 = 3'b011; lsu_rdata = 64'h7;
        @(posedge clk);
        #1;
        chk("sb_clear7", 64'(hazard), 64'd0);

        // Re-issue, then issue and writeback of rd=7 together: set wins.
        @(negedge clk);
        lsu_valid = 1'b0; ld_issue = 1'b1; ld_issue_rd = 5'd7;
        @(posedge clk);
        @(negedge clk);
        lsu_valid = 1'b1; lsu_rd = 5'd7;
        @(posedge clk);
        #1;
        chk("sb_set_wins", 64'(hazard), 64'd1);
        @(negedge clk);
        ld_issue = 1'b0;
        @(posedge clk);
        #1;
        chk("sb_final_clear", 64'(hazard), 64'd0);

        // Asynchronous reset with a live write and busy[9] set.
        @(negedge clk);
        lsu_valid = 1'b0; ld_issue = 1'b1; ld_issue_rd = 5'd9; q_rs1 = 5'd9; q_rs2 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        @(posedge clk);
        #1;
        chk("pre_rst_wen", 64'(rf_wen), 64'd1);
        chk("pre_rst_hazard", 64'(hazard), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_wen", 64'(rf_wen), 64'd0);
        chk("async_rst_hazard", 64'(hazard), 64'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish before 100000");
        $fatal(1);
    end

endmodule
